// File: rtl/control_unit.sv
// rtl/control_unit.sv - microprogram FSM sequencing the 16-bit ALU datapath
module control_unit (
   input  logic        clk,
   input  logic        rst_b,
   input  logic [3:0]  s,
   input  logic        start,
   input  logic        q0,
   input  logic        q_1,
   input  logic        a_16,
   input  logic        cmp_cnt_m4,
   input  logic [3:0]  cnt,
   output logic [18:0] c,
   output logic        finish
);

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_LOAD   = 4'd1;
   localparam logic [3:0] ST_EXEC   = 4'd2;
   localparam logic [3:0] ST_MTEST  = 4'd3;
   localparam logic [3:0] ST_MSHIFT = 4'd4;
   localparam logic [3:0] ST_DSHIFT = 4'd5;
   localparam logic [3:0] ST_DOP    = 4'd6;
   localparam logic [3:0] ST_DSET   = 4'd7;
   localparam logic [3:0] ST_DCORR  = 4'd8;
   localparam logic [3:0] ST_OUTA   = 4'd9;
   localparam logic [3:0] ST_OUTQ   = 4'd10;
   localparam logic [3:0] ST_DONE   = 4'd11;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [3:0] op;

   // Multiply and divide return two words (A then Q); everything else returns A only.
   logic op_two_words;
   assign op_two_words = (op == OP_MUL) || (op == OP_DIV);

   // State and opcode register; the opcode is captured only when leaving IDLE.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state <= ST_IDLE;
         op    <= 4'd0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && start)
            op <= s;
      end
   end

   // Next-state sequencing.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD: begin
            if (op[3])
               state_nxt = ST_DONE;
            else if (op == OP_MUL)
               state_nxt = ST_MTEST;
            else if (op == OP_DIV)
               state_nxt = ST_DSHIFT;
            else
               state_nxt = ST_EXEC;
         end
         ST_EXEC:   state_nxt = ST_OUTA;
         ST_MTEST:  state_nxt = ST_MSHIFT;
         ST_MSHIFT: state_nxt = (cnt == 4'd15) ? ST_OUTA : ST_MTEST;
         ST_DSHIFT: state_nxt = ST_DOP;
         ST_DOP:    state_nxt = ST_DSET;
         ST_DSET:   state_nxt = cmp_cnt_m4 ? ST_DCORR : ST_DSHIFT;
         ST_DCORR:  state_nxt = ST_OUTA;
         ST_OUTA:   state_nxt = op_two_words ? ST_OUTQ : ST_DONE;
         ST_OUTQ:   state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Control strobe decode; held at zero while reset is asserted.
   always_comb begin
      c      = 19'd0;
      finish = 1'b0;
      if (rst_b) begin
         case (state)
            ST_LOAD: begin
               c[0]  = 1'b1;
               c[1]  = 1'b1;
               c[2]  = 1'b1;
               c[3]  = 1'b1;
               c[17] = 1'b1;
            end
            ST_EXEC: begin
               c[18] = 1'b1;
               case (op)
                  OP_ADD:  c[4]  = 1'b1;
                  OP_SUB:  c[5]  = 1'b1;
                  OP_AND:  c[12] = 1'b1;
                  OP_OR:   c[13] = 1'b1;
                  OP_XOR:  c[14] = 1'b1;
                  OP_NOT:  c[15] = 1'b1;
                  default: ;
               endcase
            end
            ST_MTEST: begin
               // Booth pair 10 subtracts M, 01 adds M, 00/11 leaves A alone.
               if (q0 && !q_1)
                  c[5] = 1'b1;
               else if (!q0 && q_1)
                  c[4] = 1'b1;
            end
            ST_MSHIFT: begin
               c[6] = 1'b1;
               c[9] = 1'b1;
            end
            ST_DSHIFT: c[7] = 1'b1;
            ST_DOP: begin
               // Non-restoring step: negative partial remainder adds M back, else subtracts.
               if (a_16)
                  c[4] = 1'b1;
               else
                  c[5] = 1'b1;
            end
            ST_DSET: begin
               c[8] = 1'b1;
               c[9] = 1'b1;
            end
            ST_DCORR: if (a_16) c[16] = 1'b1;
            ST_OUTA:  c[10] = 1'b1;
            ST_OUTQ:  c[11] = 1'b1;
            ST_DONE:  finish = 1'b1;
            default:  ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table-driven bench for control_unit
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst_b;
   logic [3:0]  s;
   logic        start;
   logic        q0;
   logic        q_1;
   logic        a_16;
   logic        cmp_cnt_m4;
   logic [3:0]  cnt;
   logic [18:0] c;
   logic        finish;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [18:0] C_LOAD  = 19'h2000F;
   localparam logic [18:0] C_OUTA  = 19'h00400;
   localparam logic [18:0] C_OUTQ  = 19'h00800;
   localparam logic [18:0] C_ADDM  = 19'h00010;
   localparam logic [18:0] C_SUBM  = 19'h00020;
   localparam logic [18:0] C_MSH   = 19'h00240;
   localparam logic [18:0] C_DSH   = 19'h00080;
   localparam logic [18:0] C_DSET  = 19'h00300;
   localparam logic [18:0] C_REST  = 19'h10000;

   control_unit dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .s          (s),
      .start      (start),
      .q0         (q0),
      .q_1        (q_1),
      .a_16       (a_16),
      .cmp_cnt_m4 (cmp_cnt_m4),
      .cnt        (cnt),
      .c          (c),
      .finish     (finish)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_b;
      logic [3:0]  s;
      logic        start;
      logic        q0;
      logic        q_1;
      logic        a_16;
      logic        cmp;
      logic [3:0]  cnt;
      logic [18:0] exp_c;
      logic        exp_fin;
      string       name;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic [3:0] sv, input logic st,
                               input logic qa, input logic qb, input logic a16,
                               input logic cm, input logic [3:0] cn,
                               input logic [18:0] ec, input logic ef, input string nm);
      vec_t v;
      v.rst_b = r; v.s = sv; v.start = st; v.q0 = qa; v.q_1 = qb; v.a_16 = a16;
      v.cmp = cm; v.cnt = cn; v.exp_c = ec; v.exp_fin = ef; v.name = nm;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rst_b = v.rst_b; s = v.s; start = v.start; q0 = v.q0; q_1 = v.q_1;
      a_16 = v.a_16; cmp_cnt_m4 = v.cmp; cnt = v.cnt;
   endtask

   // Compare at the falling edge, then advance to just after the next rising edge.
   task automatic step(input logic [18:0] ec, input logic ef, input string nm);
      @(negedge clk);
      n_checks++;
      if (c === ec && finish === ef)
         n_pass++;
      else
         $display("FAIL %s: c=%05h finish=%b, expected c=%05h finish=%b", nm, c, finish, ec, ef);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst_b = 1'b1; s = 4'd0; start = 1'b0; q0 = 1'b0; q_1 = 1'b0;
      a_16 = 1'b0; cmp_cnt_m4 = 1'b0; cnt = 4'd0;
   endtask

   initial begin
      // Cycle-by-cycle vectors: reset, simple ops, reserved, short MUL, DIV, start ignored.
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 19'h0, 0, "reset0"));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 19'h0, 0, "reset1"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 0, "idle"));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 19'h0, 0, "add_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_LOAD, 0, "add_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h40010, 0, "add_exec"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTA, 0, "add_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "add_done"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 0, "add_idle"));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 19'h0, 0, "sub_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_LOAD, 0, "sub_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h40020, 0, "sub_exec"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTA, 0, "sub_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "sub_done"));
      vecs.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 19'h0, 0, "and_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_LOAD, 0, "and_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h41000, 0, "and_exec"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTA, 0, "and_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "and_done"));
      vecs.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 19'h0, 0, "xor_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_LOAD, 0, "xor_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h44000, 0, "xor_exec"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTA, 0, "xor_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "xor_done"));
      vecs.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 19'h0, 0, "not_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_LOAD, 0, "not_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h48000, 0, "not_exec"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTA, 0, "not_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "not_done"));
      vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 19'h0, 0, "rsv_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_LOAD, 0, "rsv_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "rsv_done"));
      vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 15, 19'h0, 0, "mul_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 15, C_LOAD, 0, "mul_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 15, 19'h0, 0, "mul_mtest00"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 15, C_MSH, 0, "mul_mshift"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTA, 0, "mul_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_OUTQ, 0, "mul_outq"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "mul_done"));
      vecs.push_back(mk(1, 3, 1, 0, 0, 1, 1, 0, 19'h0, 0, "div_start"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_LOAD, 0, "div_load"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_DSH, 0, "div_dshift"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_ADDM, 0, "div_dop_neg"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_DSET, 0, "div_dset"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_REST, 0, "div_dcorr"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_OUTA, 0, "div_outa"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, C_OUTQ, 0, "div_outq"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 19'h0, 1, "div_done"));
      vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 19'h0, 0, "or_start"));
      vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, C_LOAD, 0, "or_load_start_hi"));
      vecs.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0, 19'h42000, 0, "or_exec_start_hi"));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, C_OUTA, 0, "or_outa_start_hi"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 1, "or_done"));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 19'h0, 0, "or_idle"));

      idle_inputs();
      rst_b = 1'b0;
      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         drive(vecs[i]);
         step(vecs[i].exp_c, vecs[i].exp_fin, vecs[i].name);
      end

      // Full 16-iteration multiply with Booth patterns rotating through 10, 01, 11.
      idle_inputs();
      s = 4'd2; start = 1'b1;
      step(19'h0, 0, "mulf_start");
      start = 1'b0;
      step(C_LOAD, 0, "mulf_load");
      for (int it = 0; it < 16; it++) begin
         cnt = 4'(it);
         case (it % 3)
            0: begin q0 = 1'b1; q_1 = 1'b0; step(C_SUBM, 0, "mulf_mtest10"); end
            1: begin q0 = 1'b0; q_1 = 1'b1; step(C_ADDM, 0, "mulf_mtest01"); end
            default: begin q0 = 1'b1; q_1 = 1'b1; step(19'h0, 0, "mulf_mtest11"); end
         endcase
         step(C_MSH, 0, "mulf_mshift");
      end
      cnt = 4'd0;
      step(C_OUTA, 0, "mulf_outa");
      step(C_OUTQ, 0, "mulf_outq");
      step(19'h0, 1, "mulf_done");
      step(19'h0, 0, "mulf_idle");

      // Divide with a positive remainder, one extra loop, and no final correction.
      idle_inputs();
      s = 4'd3; start = 1'b1;
      step(19'h0, 0, "divb_start");
      start = 1'b0;
      step(C_LOAD, 0, "divb_load");
      step(C_DSH, 0, "divb_dshift1");
      a_16 = 1'b0;
      step(C_SUBM, 0, "divb_dop_pos");
      cmp_cnt_m4 = 1'b0;
      step(C_DSET, 0, "divb_dset_loop");
      step(C_DSH, 0, "divb_dshift2");
      a_16 = 1'b1;
      step(C_ADDM, 0, "divb_dop_neg");
      cmp_cnt_m4 = 1'b1;
      step(C_DSET, 0, "divb_dset_end");
      a_16 = 1'b0;
      step(19'h0, 0, "divb_dcorr_none");
      step(C_OUTA, 0, "divb_outa");
      step(C_OUTQ, 0, "divb_outq");
      step(19'h0, 1, "divb_done");

      // Reset in the middle of a multiply aborts straight back to IDLE.
      idle_inputs();
      s = 4'd2; start = 1'b1;
      step(19'h0, 0, "mulr_start");
      start = 1'b0; q0 = 1'b1; q_1 = 1'b0; cnt = 4'd3;
      step(C_LOAD, 0, "mulr_load");
      step(C_SUBM, 0, "mulr_mtest");
      rst_b = 1'b0;
      step(19'h0, 0, "mulr_reset_forced");
      rst_b = 1'b1;
      step(19'h0, 0, "mulr_idle1");
      step(19'h0, 0, "mulr_idle2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
